pipeline_ctrl: RTL and testbench

//   Central stall/flush scheduler for the 5-stage pipeline. Drives stall/flush of the IF/ID, ID/EX,
//   EX/MEM and MEM/WB registers and the PC hold. Resolves load-use, EX busy, data-memory wait,
//   EX redirect and trap events by fixed priority. Sits beside the datapath in the cpu top.

---
 rtl/cotm32_pipeline_pkg.sv | 38 +++
 rtl/pipe_hazard_unit.sv | 25 ++
 rtl/pipeline_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cotm32_pipeline_pkg.sv
// Shared pipeline-control types: scheduler states, per-register stall/flush
// pair and stage index constants.
package cotm32_pipeline_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    TRAP     = 2'd3
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_ctl_t;

  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;
  localparam int NUM_STG   = 4;

  typedef pipe_ctl_t [NUM_STG-1:0] pipe_ctl_vec_t;

  // Bit i of st/fl controls the register at stage index i.
  function automatic pipe_ctl_vec_t ctl_vec(
    input logic [NUM_STG-1:0] st,
    input logic [NUM_STG-1:0] fl
  );
    pipe_ctl_vec_t v;
    for (int i = 0; i < NUM_STG; i++) begin
      v[i].stall = st[i];
      v[i].flush = fl[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational load-use hazard detect between the ID and EX stages.
module pipe_hazard_unit (
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_valid,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_is_load,
  output logic       o_load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic ld_live;

  assign ld_live = i_id_valid && i_ex_valid &&
                   i_ex_is_load && (i_ex_rd != 5'd0);
  assign rs1_hit = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign rs2_hit = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

  assign o_load_use = ld_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Define PIPE_CTRL_PERF_EN to add stall-cycle and flush-event counters.
module pipeline_ctrl
  import cotm32_pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 64,
  parameter int TRAP_BUBBLES = 2
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int PERF_CNT_W   = 32
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_valid,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_is_load,
  input  logic       i_ex_busy,
  input  logic       i_ex_redirect,
  input  logic       i_mem_req,
  input  logic       i_mem_ready,
  input  logic       i_trap,
  output logic       o_pc_stall,
  output logic       o_stall_ifid,
  output logic       o_stall_idex,
  output logic       o_stall_exmem,
  output logic       o_stall_memwb,
  output logic       o_flush_ifid,
  output logic       o_flush_idex,
  output logic       o_flush_exmem,
  output logic       o_flush_memwb,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_CNT_W-1:0] o_perf_stall_cyc,
  output logic [PERF_CNT_W-1:0] o_perf_flush_evt,
`endif
  output logic [1:0] o_state,
  output logic       o_mem_timeout
);

  localparam int TCNT_W = $clog2(TRAP_BUBBLES + 1);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_INIT =
    TCNT_W'(TRAP_BUBBLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX =
    WCNT_W'(MEM_TIMEOUT);

  pipe_ctrl_state_t  state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q, timeout_d;

  pipe_ctl_vec_t ctl;
  logic          pc_stall;
  logic          load_use;
  logic          mem_wait;

  pipe_hazard_unit u_hazard (
    .i_id_valid   (i_id_valid),
    .i_id_rs1     (i_id_rs1),
    .i_id_rs2     (i_id_rs2),
    .i_id_use_rs1 (i_id_use_rs1),
    .i_id_use_rs2 (i_id_use_rs2),
    .i_ex_valid   (i_ex_valid),
    .i_ex_rd      (i_ex_rd),
    .i_ex_is_load (i_ex_is_load),
    .o_load_use   (load_use)
  );

  assign mem_wait = i_mem_req && !i_mem_ready;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    wcnt_d   = wcnt_q;
    pc_stall = 1'b0;
    ctl      = '0;
    unique case (state_q)
      INIT: begin
        ctl     = ctl_vec(4'b0000, 4'b1111);
        state_d = RUN;
      end
      RUN: begin
        if (i_trap) begin
          ctl     = ctl_vec(4'b0000, 4'b1111);
          state_d = TRAP;
          tcnt_d  = TCNT_INIT;
        end else if (mem_wait) begin
          pc_stall = 1'b1;
          ctl      = ctl_vec(4'b0111, 4'b1000);
          state_d  = MEM_WAIT;
          wcnt_d   = WCNT_W'(1);
        end else if (i_ex_busy) begin
          pc_stall = 1'b1;
          ctl      = ctl_vec(4'b0011, 4'b0100);
        end else if (i_ex_redirect) begin
          ctl = ctl_vec(4'b0000, 4'b0011);
        end else if (load_use) begin
          pc_stall = 1'b1;
          ctl      = ctl_vec(4'b0001, 4'b0010);
        end
      end
      MEM_WAIT: begin
        // A trap cannot commit while the MEM instruction is incomplete.
        if (!i_mem_ready) begin
          pc_stall = 1'b1;
          ctl      = ctl_vec(4'b0111, 4'b1000);
          if (wcnt_q != WCNT_MAX) begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      TRAP: begin
        ctl = ctl_vec(4'b0000, 4'b0001);
        if (i_trap) begin
          tcnt_d = TCNT_INIT;
        end else if (tcnt_q == '0) begin
          state_d = RUN;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
    timeout_d = timeout_q || (wcnt_d == WCNT_MAX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= INIT;
      tcnt_q    <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_pc_stall    = pc_stall;
  assign o_stall_ifid  = ctl[STG_IFID].stall;
  assign o_stall_idex  = ctl[STG_IDEX].stall;
  assign o_stall_exmem = ctl[STG_EXMEM].stall;
  assign o_stall_memwb = ctl[STG_MEMWB].stall;
  assign o_flush_ifid  = ctl[STG_IFID].flush;
  assign o_flush_idex  = ctl[STG_IDEX].flush;
  assign o_flush_exmem = ctl[STG_EXMEM].flush;
  assign o_flush_memwb = ctl[STG_MEMWB].flush;
  assign o_state       = state_q;
  assign o_mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [PERF_CNT_W-1:0] flush_evt_q, flush_evt_d;
  logic                  flush_evt;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_evt_d = flush_evt_q;
    flush_evt   = 1'b0;
    for (int i = 0; i < NUM_STG; i++) begin
      flush_evt = flush_evt | ctl[i].flush;
    end
    flush_evt = flush_evt && (state_q != INIT);
    if (pc_stall && (stall_cyc_q != '1)) begin
      stall_cyc_d = stall_cyc_q + 1'b1;
    end
    if (flush_evt && (flush_evt_q != '1)) begin
      flush_evt_d = flush_evt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cyc_q <= '0;
      flush_evt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_evt_q <= flush_evt_d;
    end
  end

  assign o_perf_stall_cyc = stall_cyc_q;
  assign o_perf_flush_evt = flush_evt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl against a rule-level model.
module tb_pipeline_ctrl;

  localparam int MEM_TIMEOUT  = 64;
  localparam int TRAP_BUBBLES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_id_valid = 1'b0;
  logic [4:0] i_id_rs1 = '0;
  logic [4:0] i_id_rs2 = '0;
  logic       i_id_use_rs1 = 1'b0;
  logic       i_id_use_rs2 = 1'b0;
  logic       i_ex_valid = 1'b0;
  logic [4:0] i_ex_rd = '0;
  logic       i_ex_is_load = 1'b0;
  logic       i_ex_busy = 1'b0;
  logic       i_ex_redirect = 1'b0;
  logic       i_mem_req = 1'b0;
  logic       i_mem_ready = 1'b0;
  logic       i_trap = 1'b0;

  logic       o_pc_stall;
  logic       o_stall_ifid, o_stall_idex;
  logic       o_stall_exmem, o_stall_memwb;
  logic       o_flush_ifid, o_flush_idex;
  logic       o_flush_exmem, o_flush_memwb;
  logic [1:0] o_state;
  logic       o_mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] o_perf_stall_cyc;
  logic [31:0] o_perf_flush_evt;
`endif

  pipeline_ctrl #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .TRAP_BUBBLES (TRAP_BUBBLES)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_id_valid    (i_id_valid),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_valid    (i_ex_valid),
    .i_ex_rd       (i_ex_rd),
    .i_ex_is_load  (i_ex_is_load),
    .i_ex_busy     (i_ex_busy),
    .i_ex_redirect (i_ex_redirect),
    .i_mem_req     (i_mem_req),
    .i_mem_ready   (i_mem_ready),
    .i_trap        (i_trap),
    .o_pc_stall    (o_pc_stall),
    .o_stall_ifid  (o_stall_ifid),
    .o_stall_idex  (o_stall_idex),
    .o_stall_exmem (o_stall_exmem),
    .o_stall_memwb (o_stall_memwb),
    .o_flush_ifid  (o_flush_ifid),
    .o_flush_idex  (o_flush_idex),
    .o_flush_exmem (o_flush_exmem),
    .o_flush_memwb (o_flush_memwb),
`ifdef PIPE_CTRL_PERF_EN
    .o_perf_stall_cyc (o_perf_stall_cyc),
    .o_perf_flush_evt (o_perf_flush_evt),
`endif
    .o_state       (o_state),
    .o_mem_timeout (o_mem_timeout)
  );

  always #5 clk = ~clk;

  // Vectors ordered {memwb, exmem, idex, ifid}.
  typedef struct {
    logic        pc;
    logic [3:0]  st;
    logic [3:0]  fl;
    logic [1:0]  state;
    logic        to;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: mode 0..3 = INIT, RUN, MEM_WAIT, TRAP.
  int          m_mode = 0;
  int          m_trap_left = 0;
  int          m_waits = 0;
  bit          m_to = 1'b0;
  logic [31:0] m_ps = '0;
  logic [31:0] m_pf = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t       e;
    logic [3:0] st;
    logic [3:0] fl;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e  = q.pop_front();
        st = {o_stall_memwb, o_stall_exmem, o_stall_idex, o_stall_ifid};
        fl = {o_flush_memwb, o_flush_exmem, o_flush_idex, o_flush_ifid};
        chk("pc_stall", 32'(o_pc_stall), 32'(e.pc));
        chk("stall", 32'(st), 32'(e.st));
        chk("flush", 32'(fl), 32'(e.fl));
        chk("state", 32'(o_state), 32'(e.state));
        chk("mem_timeout", 32'(o_mem_timeout), 32'(e.to));
        chk("stall_and_flush", 32'(st & fl), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", o_perf_stall_cyc, e.ps);
        chk("perf_flush", o_perf_flush_evt, e.pf);
`endif
      end
    end
  end

  function automatic bit load_use();
    bit hit1;
    bit hit2;
    hit1 = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    hit2 = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    return i_id_valid && i_ex_valid && i_ex_is_load &&
           (i_ex_rd != 5'd0) && (hit1 || hit2);
  endfunction

  // One cycle: predict outputs from the priority rules, push, advance.
  task automatic step();
    exp_t e;
    int   n_mode;
    int   n_left;
    int   n_waits;
    if (!rst_n) begin
      m_mode = 0; m_trap_left = 0; m_waits = 0;
      m_to = 1'b0; m_ps = '0; m_pf = '0;
    end
    e.pc = 1'b0; e.st = 4'b0000; e.fl = 4'b0000;
    e.state = 2'(m_mode); e.to = m_to;
    e.ps = m_ps; e.pf = m_pf;
    n_mode = m_mode; n_left = m_trap_left; n_waits = m_waits;
    case (m_mode)
      0: begin
        e.fl = 4'b1111;
        n_mode = 1;
      end
      1: begin
        if (i_trap) begin
          e.fl = 4'b1111;
          n_mode = 3;
          n_left = TRAP_BUBBLES;
        end else if (i_mem_req && !i_mem_ready) begin
          e.pc = 1'b1; e.st = 4'b0111; e.fl = 4'b1000;
          n_mode = 2;
          n_waits = 1;
        end else if (i_ex_busy) begin
          e.pc = 1'b1; e.st = 4'b0011; e.fl = 4'b0100;
        end else if (i_ex_redirect) begin
          e.fl = 4'b0011;
        end else if (load_use()) begin
          e.pc = 1'b1; e.st = 4'b0001; e.fl = 4'b0010;
        end
      end
      2: begin
        if (!i_mem_ready) begin
          e.pc = 1'b1; e.st = 4'b0111; e.fl = 4'b1000;
          n_waits = m_waits + 1;
        end else begin
          n_mode = 1;
          n_waits = 0;
        end
      end
      default: begin
        e.fl = 4'b0001;
        n_left = m_trap_left - 1;
        if (i_trap) n_left = TRAP_BUBBLES;
        if (n_left == 0) n_mode = 1;
      end
    endcase
    q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      m_mode = n_mode;
      m_trap_left = n_left;
      m_waits = n_waits;
      if (n_waits >= MEM_TIMEOUT) m_to = 1'b1;
      if (e.pc && m_ps != '1) m_ps = m_ps + 1;
      if (e.fl != 0 && e.state != 0 && m_pf != '1) m_pf = m_pf + 1;
    end
  endtask

  task automatic drive_rand(bit hold_wait);
    i_id_valid    = ($urandom_range(0, 3) != 0);
    i_id_rs1      = 5'($urandom_range(0, 3));
    i_id_rs2      = 5'($urandom_range(0, 3));
    i_id_use_rs1  = ($urandom_range(0, 1) == 1);
    i_id_use_rs2  = ($urandom_range(0, 1) == 1);
    i_ex_valid    = ($urandom_range(0, 3) != 0);
    i_ex_rd       = 5'($urandom_range(0, 3));
    i_ex_is_load  = ($urandom_range(0, 1) == 1);
    i_ex_busy     = ($urandom_range(0, 9) == 0);
    i_ex_redirect = ($urandom_range(0, 6) == 0);
    i_mem_req     = ($urandom_range(0, 4) == 0);
    i_mem_ready   = ($urandom_range(0, 2) == 0);
    i_trap        = ($urandom_range(0, 19) == 0);
    if (hold_wait) begin
      i_mem_req   = 1'b1;
      i_mem_ready = 1'b0;
      i_trap      = 1'b0;
    end
  endtask

  task automatic drive_idle();
    i_id_valid = 1'b0; i_ex_valid = 1'b0;
    i_ex_busy = 1'b0; i_ex_redirect = 1'b0;
    i_mem_req = 1'b0; i_mem_ready = 1'b1;
    i_trap = 1'b0;
  endtask

  task automatic run_rand(int n, bit hold_wait);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_rand(hold_wait);
      step();
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 8; i++) begin
      if (m_mode == 1) break;
      @(negedge clk);
      drive_idle();
      step();
    end
  endtask

  task automatic do_reset(int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      drive_rand(0);
      step();
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_rand(0);
    step();
  endtask

  initial begin
    do_reset(3);
    run_rand(400, 0);
    settle();
    run_rand(70, 1);
    settle();
    run_rand(300, 0);
    settle();
    run_rand(5, 1);
    do_reset(2);
    run_rand(50, 0);
    settle();
    @(negedge clk);
    drive_rand(0);
    i_trap = 1'b1;
    step();
    do_reset(1);
    run_rand(200, 0);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    #5;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
